mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Memory-stage load/store unit that sits directly downstream of the execute-stage ALU. It consumes the 32-bit ALU result as either an effective address (loads/stores) or a pass-through writeback value. It runs a req/ack transaction to data memory, with byte-lane steering for stores and alignment/sign-extension for loads. It also detects misaligned or illegal accesses and bounds every memory wait with a watchdog timeout.

## Interface
- `TIMEOUT`, default 255: maximum cycles `mem_req` may stay high without `mem_ack` (1..255).
- `clock`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  execute stage presents an operation
- `in_ready`  out  1  high only in IDLE; an op is accepted when `in_valid && in_ready`
- `in_is_load`, `in_is_store`  in  1 each  operation class
- `in_funct3`  in  3  RV32I width/sign code
- `in_alu_res`  in  32  ALU result: effective address or pass-through value
- `in_store_data`  in  32  rs2 value
- `in_rd`  in  5  destination register
- `mem_req`  out  1  memory request, registered
- `mem_we`  out  1  1 = write
- `mem_addr`  out  32  word address, `{addr[31:2],2'b00}`
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  32  lane-replicated store data
- `mem_ack`  in  1  memory completion; valid only while `mem_req` = 1
- `mem_rdata`  in  32  read word, valid when `mem_ack` = 1
- `out_valid`  out  1  one-cycle result pulse
- `out_data`  out  32  writeback value
- `out_rd`  out  5  captured `rd`
- `out_wb`  out  1  register write required
- `out_fault`  out  1  misaligned, illegal or timed-out access (qualified by `out_valid`)

## Operation
- FSM states:
  - IDLE: on accept, capture all inputs.
    - Classify the op as pass-through, fault, or memory.
    - Pass-through and fault go to DONE.
    - Memory goes to REQ.
  - REQ: `mem_req` = 1, with addr/we/be/wdata held stable.
    - On `mem_ack`, capture `mem_rdata` and go to DONE.
    - On watchdog expiry, go to DONE with fault.
  - DONE: `out_valid` = 1 for exactly one cycle, then IDLE.
- Pass-through (neither load nor store): `out_data` = `in_alu_res`, `out_wb` = 1, no memory access.
- Fault, no request issued, `out_wb` = 0, `out_data` = 0:
  - `in_is_load` and `in_is_store` both set.
  - Load `funct3` ∈ {3,6,7}.
  - Store `funct3` ≥ 3.
  - Halfword with `addr[0]` = 1.
  - Word with `addr[1:0]` ≠ 0.
- Store encoding:
  - SB: `be` = `4'b0001 << addr[1:0]`, `wdata` = `{4{sd[7:0]}}`.
  - SH: `be` = `addr[1] ? 4'b1100 : 4'b0011`, `wdata` = `{2{sd[15:0]}}`.
  - SW: `be` = `4'b1111`, `wdata` = `sd`.
  - Result: `out_wb` = 0, `out_data` = 0.
- Load: `mem_we` = 0, `mem_be` = access lanes. The selected byte/half comes from the captured word at lane `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Result: `out_wb` = 1.
- Watchdog: counter cleared on entry to REQ and incremented each REQ cycle without ack.
  - When it reaches `TIMEOUT` without ack: drop `mem_req`, go to DONE, `out_fault` = 1, `out_wb` = 0.
- `mem_ack` outside REQ is ignored. An ack in the same cycle as the counter reaching `TIMEOUT` counts as success.

## Timing
- Reset values:
  - State IDLE, `in_ready` = 1.
  - `mem_req`, `mem_we`, `out_valid`, `out_wb`, `out_fault` = 0.
  - `mem_be` = 0, `mem_addr`/`mem_wdata`/`out_data` = 0, `out_rd` = 0, watchdog counter = 0.
- Reset mid-transaction abandons the operation. `mem_req` is low the cycle after reset is sampled, and no `out_valid` is produced.
- Accept at cycle T:
  - Pass-through/fault: `out_valid` at T+1, `in_ready` at T+2.
  - Memory: `mem_req` rises at T+1. With ack at T+1+k, `out_valid` at T+2+k and `in_ready` at T+3+k.
- `out_*` hold their values until the next DONE. Only `out_valid` pulses.
- `in_ready` is a pure function of state (no combinational path from `in_valid`).

## Test plan
- Pass-through: `alu_res` = `0x0000_1234`, `rd` = 5 → `out_valid` at T+1, `out_data` = `0x1234`, `out_wb` = 1, `mem_req` never asserted.
- SB: addr `0x103`, `sd` = `0xAABBCC7F` → `mem_addr` = `0x100`, `be` = `1000`, `wdata` = `0x7F7F7F7F`. `mem_req` stays high through 3 wait cycles. Ack → `out_valid` next cycle, `out_wb` = 0.
- LB/LBU/LH: `rdata` = `0x80FF_7F01`:
  - LB @ +1 → `0x0000007F`.
  - LB @ +2 → `0xFFFFFFFF`.
  - LBU @ +3 → `0x00000080`.
  - LH @ +2 → `0xFFFF80FF`.
- Misaligned: LW @ `0x102` → `out_valid` at T+1, `out_fault` = 1, `out_wb` = 0, no `mem_req`. The same applies to LH @ `0x101` and funct3 = 3 loads.
- Timeout: `TIMEOUT` = 4, no ack → `mem_req` high exactly 4 cycles, then `out_valid` with `out_fault` = 1. Ack in the 4th cycle → success, not a fault.
- Reset: assert `reset` during REQ → next cycle `mem_req` = 0, `in_ready` = 1, no `out_valid`. A later load completes normally.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit with byte steering, load alignment and watchdog
module mem_stage_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_res,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_wb,
    output logic        out_fault
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2;
    logic [1:0]  state;
    logic [7:0]  wd_cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        ld_q;
    logic [4:0]  rd_q;
    logic        is_mem, bad_f3, misaligned, fault;
    logic [3:0]  be;
    logic [31:0] wdata, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    always_comb begin
        is_mem     = in_is_load | in_is_store;
        bad_f3     = in_is_load ? (in_funct3 == 3'd3 || in_funct3 >= 3'd6) : (in_is_store && in_funct3 >= 3'd3);
        misaligned = is_mem && ((in_funct3[1:0] == 2'd1 && in_alu_res[0]) || (in_funct3[1:0] == 2'd2 && in_alu_res[1:0] != 2'd0));
        fault      = (in_is_load & in_is_store) | bad_f3 | misaligned;
        be         = in_funct3[1:0] == 2'd0 ? 4'b0001 << in_alu_res[1:0] :
                     in_funct3[1:0] == 2'd1 ? (in_alu_res[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata      = in_funct3[1:0] == 2'd0 ? {4{in_store_data[7:0]}} :
                     in_funct3[1:0] == 2'd1 ? {2{in_store_data[15:0]}} : in_store_data;
        ld_byte    = mem_rdata[{off_q, 3'b000} +: 8];
        ld_half    = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        // funct3[2] selects the unsigned variants of LB/LH
        ld_data    = f3_q[1:0] == 2'd0 ? {{24{~f3_q[2] & ld_byte[7]}}, ld_byte} :
                     f3_q[1:0] == 2'd1 ? {{16{~f3_q[2] & ld_half[15]}}, ld_half} : mem_rdata;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wd_cnt    <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            ld_q      <= 1'b0;
            rd_q      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            out_data  <= '0;
            out_rd    <= '0;
            out_wb    <= 1'b0;
            out_fault <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid && is_mem && !fault) begin
                state     <= REQ;
                wd_cnt    <= '0;
                f3_q      <= in_funct3;
                off_q     <= in_alu_res[1:0];
                ld_q      <= in_is_load;
                rd_q      <= in_rd;
                mem_req   <= 1'b1;
                mem_we    <= in_is_store;
                mem_addr  <= {in_alu_res[31:2], 2'b00};
                mem_be    <= be;
                mem_wdata <= wdata;
            end else if (in_valid) begin
                state     <= DONE;
                out_data  <= is_mem ? 32'd0 : in_alu_res;
                out_rd    <= in_rd;
                out_wb    <= !is_mem;
                out_fault <= is_mem;
            end
        end else if (state == REQ) begin
            if (mem_ack) begin
                state     <= DONE;
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                out_data  <= ld_q ? ld_data : 32'd0;
                out_rd    <= rd_q;
                out_wb    <= ld_q;
                out_fault <= 1'b0;
            end else begin
                wd_cnt <= wd_cnt + 8'd1;
                if (wd_cnt == 8'(TIMEOUT - 1)) begin
                    state     <= DONE;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    out_data  <= '0;
                    out_rd    <= rd_q;
                    out_wb    <= 1'b0;
                    out_fault <= 1'b1;
                end
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: table-driven directed bench for mem_stage_lsu with TIMEOUT = 4
module tb_mem_stage_lsu;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic        in_is_load = 1'b0, in_is_store = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_alu_res = '0, in_store_data = '0;
    logic [4:0]  in_rd = '0;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_be;
    logic        out_valid, out_wb, out_fault;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    int checks = 0, failures = 0;

    mem_stage_lsu #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
        .in_alu_res(in_alu_res), .in_store_data(in_store_data), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
        .out_wb(out_wb), .out_fault(out_fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] alu, sd;
        logic [4:0]  rd;
        int          wt;
        logic [31:0] rdata, e_data;
        logic        e_wb, e_fault;
        int          e_reqs;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        int          e_lat;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        int reqs = 0, lat = 0;
        bit got = 0;
        logic [3:0]  be_s = '0;
        logic [31:0] wd_s = '0, ad_s = '0;
        logic        we_s = 1'b0;
        logic [31:0] held;
        @(negedge clock);
        chk({tag, ".ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_is_load = v.ld; in_is_store = v.st; in_funct3 = v.f3;
        in_alu_res = v.alu; in_store_data = v.sd; in_rd = v.rd;
        @(posedge clock);
        #1;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_alu_res = '0; in_store_data = '0; in_rd = '0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (mem_req) begin
                be_s = mem_be; wd_s = mem_wdata; ad_s = mem_addr; we_s = mem_we;
                if (reqs == v.wt) begin
                    mem_ack = 1'b1;
                    mem_rdata = v.rdata;
                end
                reqs++;
            end
            if (out_valid) begin
                got = 1;
                lat = c;
                chk({tag, ".ready_in_done"}, 32'(in_ready), 32'd0);
            end
        end
        chk({tag, ".latency"}, 32'(lat), 32'(v.e_lat));
        chk({tag, ".req_cycles"}, 32'(reqs), 32'(v.e_reqs));
        chk({tag, ".data"}, out_data, v.e_data);
        chk({tag, ".wb"}, 32'(out_wb), 32'(v.e_wb));
        chk({tag, ".fault"}, 32'(out_fault), 32'(v.e_fault));
        chk({tag, ".rd"}, 32'(out_rd), 32'(v.rd));
        if (v.e_reqs > 0) begin
            chk({tag, ".be"}, 32'(be_s), 32'(v.e_be));
            chk({tag, ".addr"}, ad_s, v.alu & 32'hFFFF_FFFC);
            chk({tag, ".we"}, 32'(we_s), 32'(v.st));
            if (v.st) chk({tag, ".wdata"}, wd_s, v.e_wdata);
        end
        held = out_data;
        @(negedge clock);
        chk({tag, ".valid_one_cycle"}, 32'(out_valid), 32'd0);
        chk({tag, ".ready_after"}, 32'(in_ready), 32'd1);
        chk({tag, ".data_hold"}, out_data, v.e_data);
        chk({tag, ".hold_stable"}, out_data, held);
    endtask

    initial begin
        int seen;
        //        ld    st    f3    alu            sd             rd  wt  rdata          e_data        wb    flt  reqs be       wdata          lat
        vecs[0]  = '{1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0,        5'd5,  0, 32'h0,        32'h1234,     1'b1, 1'b0, 0, 4'b0000, 32'h0,        1};
        vecs[1]  = '{1'b0, 1'b1, 3'd0, 32'h0000_0103, 32'hAABBCC7F, 5'd1,  3, 32'h0,        32'h0,        1'b0, 1'b0, 4, 4'b1000, 32'h7F7F7F7F, 5};
        vecs[2]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0101, 32'h0,        5'd2,  0, 32'h80FF7F01, 32'h0000007F, 1'b1, 1'b0, 1, 4'b0010, 32'h0,        2};
        vecs[3]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0102, 32'h0,        5'd3,  1, 32'h80FF7F01, 32'hFFFFFFFF, 1'b1, 1'b0, 2, 4'b0100, 32'h0,        3};
        vecs[4]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'h0,        5'd4,  0, 32'h80FF7F01, 32'h00000080, 1'b1, 1'b0, 1, 4'b1000, 32'h0,        2};
        vecs[5]  = '{1'b1, 1'b0, 3'd1, 32'h0000_0102, 32'h0,        5'd6,  0, 32'h80FF7F01, 32'hFFFF80FF, 1'b1, 1'b0, 1, 4'b1100, 32'h0,        2};
        vecs[6]  = '{1'b1, 1'b0, 3'd5, 32'h0000_0100, 32'h0,        5'd7,  0, 32'h80FF7F01, 32'h00007F01, 1'b1, 1'b0, 1, 4'b0011, 32'h0,        2};
        vecs[7]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0200, 32'h0,        5'd8,  0, 32'h80FF7F01, 32'h80FF7F01, 1'b1, 1'b0, 1, 4'b1111, 32'h0,        2};
        vecs[8]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0106, 32'h12345678, 5'd9,  2, 32'h0,        32'h0,        1'b0, 1'b0, 3, 4'b1100, 32'h56785678, 4};
        vecs[9]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0208, 32'hDEADBEEF, 5'd10, 0, 32'h0,        32'h0,        1'b0, 1'b0, 1, 4'b1111, 32'hDEADBEEF, 2};
        vecs[10] = '{1'b1, 1'b0, 3'd2, 32'h0000_0102, 32'h0,        5'd11, 0, 32'h0,        32'h0,        1'b0, 1'b1, 0, 4'b0000, 32'h0,        1};
        vecs[11] = '{1'b1, 1'b0, 3'd1, 32'h0000_0101, 32'h0,        5'd12, 0, 32'h0,        32'h0,        1'b0, 1'b1, 0, 4'b0000, 32'h0,        1};
        vecs[12] = '{1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'h0,        5'd13, 0, 32'h0,        32'h0,        1'b0, 1'b1, 0, 4'b0000, 32'h0,        1};
        vecs[13] = '{1'b0, 1'b1, 3'd3, 32'h0000_0100, 32'h0,        5'd14, 0, 32'h0,        32'h0,        1'b0, 1'b1, 0, 4'b0000, 32'h0,        1};
        vecs[14] = '{1'b1, 1'b1, 3'd2, 32'h0000_0100, 32'h0,        5'd15, 0, 32'h0,        32'h0,        1'b0, 1'b1, 0, 4'b0000, 32'h0,        1};
        vecs[15] = '{1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'h0,        5'd16, -1, 32'h0,       32'h0,        1'b0, 1'b1, 4, 4'b1111, 32'h0,        5};
        vecs[16] = '{1'b1, 1'b0, 3'd2, 32'h0000_0304, 32'h0,        5'd17, 3, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b0, 4, 4'b1111, 32'h0,        5};

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.mem_req", 32'(mem_req), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.mem_be", 32'(mem_be), 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", out_data, 32'd0);
        chk("rst.out_rd", 32'(out_rd), 32'd0);
        chk("rst.out_wb", 32'(out_wb), 32'd0);
        chk("rst.out_fault", 32'(out_fault), 32'd0);

        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        chk("stray_ack.out_valid", 32'(out_valid), 32'd0);
        chk("stray_ack.in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 17; i++) run(vecs[i], $sformatf("v%0d", i));

        @(negedge clock);
        in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'd2; in_alu_res = 32'h400; in_rd = 5'd20;
        @(posedge clock);
        #1;
        in_valid = 1'b0; in_is_load = 1'b0;
        @(negedge clock);
        chk("rst_mid.req_before", 32'(mem_req), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_mid.mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (out_valid || mem_req) seen++;
        end
        chk("rst_mid.no_activity", 32'(seen), 32'd0);
        run(vecs[7], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
